// File: rtl/upht_update_unit.sv
// rtl/upht_update_unit.sv - uPHT saturating-counter update unit with 2-entry write queue
module upht_update_unit #(
    parameter int IDX_W    = 6,
    parameter int STAT_W   = 16,
    parameter int WQ_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_resolve_vld,
    input  logic              i_resolve_taken,
    input  logic [IDX_W-1:0]  i_resolve_idx,
    output logic              o_resolve_rdy,
    output logic              o_satCnt_update,
    input  logic [1:0]        i_RdCnt,
    input  logic              i_SatCnt_Miss,
    output logic              o_pht_wr_vld,
    output logic [IDX_W-1:0]  o_pht_wr_idx,
    output logic [1:0]        o_pht_wr_cnt,
    input  logic              i_pht_wr_rdy,
    output logic              o_mispred,
    output logic [STAT_W-1:0] o_mispred_cnt,
    output logic [STAT_W-1:0] o_miss_cnt
);

    // Queue is a 2-slot shift register: slot 0 is always the head.
    logic [1:0]        occ_q, occ_d;
    logic [IDX_W-1:0]  idx0_q, idx0_d, idx1_q, idx1_d;
    logic [1:0]        cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic              mispred_q, mispred_d;
    logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic       accept;
    logic       wr_pop;
    logic [1:0] base_cnt;
    logic [1:0] new_cnt;

    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    assign o_resolve_rdy   = (32'(occ_q) < WQ_DEPTH);
    assign accept          = i_resolve_vld & o_resolve_rdy;
    assign o_satCnt_update = accept & ~i_SatCnt_Miss;
    assign wr_pop          = (occ_q != 2'd0) & i_pht_wr_rdy;

    assign o_pht_wr_vld  = (occ_q != 2'd0);
    assign o_pht_wr_idx  = idx0_q;
    assign o_pht_wr_cnt  = cnt0_q;
    assign o_mispred     = mispred_q;
    assign o_mispred_cnt = mispred_cnt_q;
    assign o_miss_cnt    = miss_cnt_q;

    // Base counter: youngest queued write to the same index wins, then FIFO/miss default.
    always_comb begin
        base_cnt = i_SatCnt_Miss ? 2'b01 : i_RdCnt;
        if (occ_q == 2'd2 && idx1_q == i_resolve_idx) begin
            base_cnt = cnt1_q;
        end else if (occ_q != 2'd0 && idx0_q == i_resolve_idx) begin
            base_cnt = cnt0_q;
        end
    end

    // Two-bit saturating increment/decrement of the selected base.
    always_comb begin
        new_cnt = base_cnt;
        if (i_resolve_taken) begin
            if (base_cnt != 2'd3) new_cnt = base_cnt + 2'd1;
        end else begin
            if (base_cnt != 2'd0) new_cnt = base_cnt - 2'd1;
        end
    end

    // Write queue next state: pop shifts slot 1 into the head, push lands behind the survivors.
    always_comb begin
        occ_d  = occ_q;
        idx0_d = idx0_q;
        cnt0_d = cnt0_q;
        idx1_d = idx1_q;
        cnt1_d = cnt1_q;
        if (wr_pop) begin
            idx0_d = idx1_q;
            cnt0_d = cnt1_q;
        end
        if (accept) begin
            if ((occ_q == 2'd0) || (occ_q == 2'd1 && wr_pop)) begin
                idx0_d = i_resolve_idx;
                cnt0_d = new_cnt;
            end else begin
                idx1_d = i_resolve_idx;
                cnt1_d = new_cnt;
            end
        end
        case ({accept, wr_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Mispredict is judged against what the FIFO predicted, not against the forwarded value.
    always_comb begin
        mispred_d     = accept & ~i_SatCnt_Miss & (i_RdCnt[1] != i_resolve_taken);
        mispred_cnt_d = mispred_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        if (mispred_d && mispred_cnt_q != STAT_MAX) mispred_cnt_d = mispred_cnt_q + STAT_ONE;
        if (accept && i_SatCnt_Miss && miss_cnt_q != STAT_MAX) miss_cnt_d = miss_cnt_q + STAT_ONE;
    end

    // State registers; reset discards any pending writes and clears statistics.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            occ_q         <= 2'd0;
            idx0_q        <= '0;
            cnt0_q        <= 2'd0;
            idx1_q        <= '0;
            cnt1_q        <= 2'd0;
            mispred_q     <= 1'b0;
            mispred_cnt_q <= '0;
            miss_cnt_q    <= '0;
        end else begin
            occ_q         <= occ_d;
            idx0_q        <= idx0_d;
            cnt0_q        <= cnt0_d;
            idx1_q        <= idx1_d;
            cnt1_q        <= cnt1_d;
            mispred_q     <= mispred_d;
            mispred_cnt_q <= mispred_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

endmodule
